// File: rtl/fs_serial_ctrl.sv
// rtl/fs_serial_ctrl.sv - bit-serial a-b-bin controller around a 1-bit full-subtractor cell
module fs_serial_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             bin_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] diff_o,
    output logic             bout_o
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_sh_q, b_sh_q, diff_q;
    logic [CW-1:0]    cnt_q;
    logic             brw_q, bout_q, busy_q, done_q;

    logic             cell_a, cell_b, cell_d, cell_ba;
    logic [WIDTH-1:0] a_sh_d, b_sh_d, diff_d;
    logic [CW-1:0]    cnt_d;
    logic             last_bit;

    assign cell_a  = a_sh_q[0];
    assign cell_b  = b_sh_q[0];
    assign cell_d  = cell_a ^ cell_b ^ brw_q;
    assign cell_ba = (~cell_a & cell_b) | (~cell_a & brw_q) | (cell_b & brw_q);

    assign a_sh_d   = {1'b0, a_sh_q[WIDTH-1:1]};
    assign b_sh_d   = {1'b0, b_sh_q[WIDTH-1:1]};
    assign diff_d   = {cell_d, diff_q[WIDTH-1:1]};
    assign cnt_d    = cnt_q + 1'b1;
    assign last_bit = (cnt_q == CW'(WIDTH - 1));

    // DONE accepts a new start exactly like IDLE so held start runs back-to-back
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            diff_q  <= '0;
            cnt_q   <= '0;
            brw_q   <= 1'b0;
            bout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                S_RUN: begin
                    a_sh_q <= a_sh_d;
                    b_sh_q <= b_sh_d;
                    diff_q <= diff_d;
                    brw_q  <= cell_ba;
                    cnt_q  <= cnt_d;
                    if (last_bit) begin
                        bout_q  <= cell_ba;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                S_IDLE, S_DONE: begin
                    done_q <= 1'b0;
                    if (start_i) begin
                        a_sh_q  <= a_i;
                        b_sh_q  <= b_i;
                        brw_q   <= bin_i;
                        cnt_q   <= '0;
                        diff_q  <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_RUN;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign diff_o = diff_q;
    assign bout_o = bout_q;
endmodule

// File: tb/tb_fs_serial_ctrl.sv
// tb/tb_fs_serial_ctrl.sv - directed self-checking bench for fs_serial_ctrl
module tb_fs_serial_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic       start8, bin8, busy8, done8, bout8;
    logic [7:0] a8, b8, diff8;
    logic       start2, bin2, busy2, done2, bout2;
    logic [1:0] a2, b2, diff2;

    int checks = 0;
    int errors = 0;
    int cyc, bc, nd;
    logic [7:0] cap_diff;
    logic       cap_bout;

    always #5 clk = ~clk;

    fs_serial_ctrl #(.WIDTH(8)) u_dut8 (
        .clk_i(clk), .rst_i(rst), .start_i(start8), .a_i(a8), .b_i(b8), .bin_i(bin8),
        .busy_o(busy8), .done_o(done8), .diff_o(diff8), .bout_o(bout8)
    );

    fs_serial_ctrl #(.WIDTH(2)) u_dut2 (
        .clk_i(clk), .rst_i(rst), .start_i(start2), .a_i(a2), .b_i(b2), .bin_i(bin2),
        .busy_o(busy2), .done_o(done2), .diff_o(diff2), .bout_o(bout2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Counts busy cycles until done rises, starting from the cycle right after the accepting edge.
    task automatic wait8(output int n_cyc, output int n_busy);
        n_cyc  = 0;
        n_busy = 0;
        while (!done8 && n_cyc < 40) begin
            if (busy8) n_busy++;
            step();
            n_cyc++;
        end
    endtask

    task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic bin, input logic [7:0] ed, input logic eb);
        a8 = a; b8 = b; bin8 = bin; start8 = 1'b1;
        step();
        start8 = 1'b0;
        wait8(cyc, bc);
        chk({tag, "_latency"}, 32'(cyc), 32'd8);
        chk({tag, "_diff"}, 32'(diff8), 32'(ed));
        chk({tag, "_bout"}, 32'(bout8), 32'(eb));
        step();
        chk({tag, "_done_clear"}, 32'(done8), 32'd0);
    endtask

    initial begin
        rst = 1'b1; start8 = 0; a8 = 0; b8 = 0; bin8 = 0;
        start2 = 0; a2 = 0; b2 = 0; bin2 = 0;
        step(); step();
        chk("rst_busy", 32'(busy8), 32'd0);
        chk("rst_done", 32'(done8), 32'd0);
        chk("rst_diff", 32'(diff8), 32'd0);
        chk("rst_bout", 32'(bout8), 32'd0);
        rst = 1'b0;
        step();

        // Basic subtract with busy-width check
        a8 = 8'd100; b8 = 8'd37; bin8 = 0; start8 = 1;
        step();
        start8 = 0;
        chk("basic_busy_after_e0", 32'(busy8), 32'd1);
        wait8(cyc, bc);
        chk("basic_latency", 32'(cyc), 32'd8);
        chk("basic_busy_cycles", 32'(bc), 32'd8);
        chk("basic_busy_at_done", 32'(busy8), 32'd0);
        chk("basic_diff", 32'(diff8), 32'd63);
        chk("basic_bout", 32'(bout8), 32'd0);
        step();
        chk("basic_done_clear", 32'(done8), 32'd0);
        step(); step();
        chk("basic_diff_hold", 32'(diff8), 32'd63);

        op8("neg_5_9", 8'd5, 8'd9, 1'b0, 8'd252, 1'b1);
        op8("neg_0_0_1", 8'd0, 8'd0, 1'b1, 8'd255, 1'b1);
        op8("neg_255_255_1", 8'd255, 8'd255, 1'b1, 8'd255, 1'b1);

        // Exhaustive WIDTH=2
        for (int ai = 0; ai < 4; ai++) begin
            for (int bi = 0; bi < 4; bi++) begin
                for (int ci = 0; ci < 2; ci++) begin
                    a2 = 2'(ai); b2 = 2'(bi); bin2 = 1'(ci); start2 = 1;
                    step();
                    start2 = 0;
                    nd = 0;
                    while (!done2 && nd < 10) begin step(); nd++; end
                    chk($sformatf("w2_lat_%0d_%0d_%0d", ai, bi, ci), 32'(nd), 32'd2);
                    chk($sformatf("w2_res_%0d_%0d_%0d", ai, bi, ci), {29'd0, bout2, diff2},
                        {29'd0, 1'((ai < bi + ci) ? 1 : 0), 2'(ai - bi - ci)});
                    step();
                end
            end
        end

        // Start while busy plus input churn
        a8 = 8'd50; b8 = 8'd20; bin8 = 1; start8 = 1;
        step();
        nd = 0; cap_diff = 0; cap_bout = 1'b1;
        for (int i = 0; i < 20; i++) begin
            a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
            start8 = (i == 2);
            if (i == 2) begin a8 = 8'd1; b8 = 8'd2; end
            step();
            if (done8) begin nd++; cap_diff = diff8; cap_bout = bout8; end
        end
        start8 = 0;
        chk("churn_done_count", 32'(nd), 32'd1);
        chk("churn_diff", 32'(cap_diff), 32'd29);
        chk("churn_bout", 32'(cap_bout), 32'd0);
        chk("churn_idle", 32'(busy8), 32'd0);

        // Back-to-back with start held
        a8 = 8'd200; b8 = 8'd1; bin8 = 0; start8 = 1;
        step();
        wait8(cyc, bc);
        chk("b2b1_busy_cycles", 32'(bc), 32'd8);
        chk("b2b1_busy_low", 32'(busy8), 32'd0);
        chk("b2b1_diff", 32'(diff8), 32'd199);
        chk("b2b1_bout", 32'(bout8), 32'd0);
        a8 = 8'd7; b8 = 8'd8;
        step();
        chk("b2b2_rebusy", 32'(busy8), 32'd1);
        chk("b2b2_done_clear", 32'(done8), 32'd0);
        wait8(cyc, bc);
        chk("b2b2_busy_cycles", 32'(bc), 32'd8);
        chk("b2b2_diff", 32'(diff8), 32'd255);
        chk("b2b2_bout", 32'(bout8), 32'd1);
        start8 = 0;
        step();
        chk("b2b_end_busy", 32'(busy8), 32'd0);
        chk("b2b_end_done", 32'(done8), 32'd0);

        // Reset mid-run
        a8 = 8'd99; b8 = 8'd1; bin8 = 0; start8 = 1;
        step();
        start8 = 0;
        step(); step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_busy", 32'(busy8), 32'd0);
        chk("midrst_done", 32'(done8), 32'd0);
        chk("midrst_diff", 32'(diff8), 32'd0);
        chk("midrst_bout", 32'(bout8), 32'd0);
        nd = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (done8 || busy8) nd++;
        end
        chk("midrst_no_done", 32'(nd), 32'd0);
        op8("after_rst", 8'd10, 8'd3, 1'b0, 8'd7, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
